// File: rtl/ic7458_tester.sv
// Exhaustive self-test sequencer for a 7458 dual AND-OR gate: drives all 1024
// input vectors, samples p1y/p2y after a settle delay and records mismatches.
module ic7458_tester #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 abort,
    output logic                 p1a,
    output logic                 p1b,
    output logic                 p1c,
    output logic                 p1d,
    output logic                 p1e,
    output logic                 p1f,
    output logic                 p2a,
    output logic                 p2b,
    output logic                 p2c,
    output logic                 p2d,
    input  logic                 p1y,
    input  logic                 p2y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 first_fail_valid,
    output logic [9:0]           first_fail_vec,
    output logic [1:0]           first_fail_y
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } state_t;

    localparam logic [3:0]           SETTLE  = 4'(SETTLE_CYCLES);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    state_t      state, state_next;
    logic [9:0]  vec;
    logic [3:0]  settle_cnt;
    logic        exp1, exp2;
    logic [1:0]  miss;

    assign busy = (state == S_APPLY) || (state == S_WAIT) || (state == S_CHECK);
    assign done = (state == S_FINISH);
    assign {p1a, p1b, p1c, p1d, p1e, p1f, p2a, p2b, p2c, p2d} = busy ? vec : 10'd0;

    // Golden 7458 function evaluated on the vector currently driven.
    assign exp1 = (p1a & p1b & p1c) | (p1d & p1e & p1f);
    assign exp2 = (p2a & p2b) | (p2c & p2d);
    assign miss = {p1y != exp1, p2y != exp2};

    // NOTE: next-state logic assigns its default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (start && !abort) state_next = S_APPLY;
            S_APPLY:  state_next = (SETTLE == 4'd0) ? S_CHECK : S_WAIT;
            S_WAIT:   if (settle_cnt == 4'd1) state_next = S_CHECK;
            S_CHECK:  state_next = (vec == 10'h3FF) ? S_FINISH : S_APPLY;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (abort && state != S_IDLE) state_next = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only; every register,
    // including the result holders, is cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= S_IDLE;
            vec              <= '0;
            settle_cnt       <= '0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_y     <= '0;
        end else begin
            state <= state_next;
            if (abort && state != S_IDLE) begin
                vec  <= '0;
                pass <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            vec              <= '0;
                            pass             <= 1'b0;
                            err_count        <= '0;
                            first_fail_valid <= 1'b0;
                            first_fail_vec   <= '0;
                            first_fail_y     <= '0;
                        end
                    end
                    S_APPLY: settle_cnt <= SETTLE;
                    S_WAIT:  settle_cnt <= settle_cnt - 4'd1;
                    S_CHECK: begin
                        if (|miss) begin
                            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                            if (!first_fail_valid) begin
                                first_fail_valid <= 1'b1;
                                first_fail_vec   <= vec;
                                first_fail_y     <= miss;
                            end
                        end
                        // Pass is resolved on the last check so it is valid alongside done.
                        if (vec == 10'h3FF) begin
                            vec  <= '0;
                            pass <= !(first_fail_valid || (|miss));
                        end else begin
                            vec <= vec + 10'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ic7458_tester.sv
// Self-checking bench: four tester instances (different settle/counter widths) in
// front of a behavioural 7458 with injectable faults, checked against a vector model.
module tb_ic7458_tester;

    logic       clk = 1'b0;
    logic [3:0] rstn  = 4'b0000;
    logic [3:0] start = 4'b0000;
    logic [3:0] abort = 4'b0000;
    logic [3:0] y1 = 4'b0000;
    logic [3:0] y2 = 4'b0000;
    wire  [3:0] done_w, busy_w, pass_w, ffv_w;
    wire  [9:0] pv    [4];
    wire  [9:0] ffvec [4];
    wire  [1:0] ffy   [4];
    wire  [9:0] ecw   [4];

    int fm [4] = '{0, 0, 0, 0};   // 0 good, 1 p2y stuck-0, 2 p1y stuck-1, 3 random flips
    bit flip1 [1024];
    bit flip2 [1024];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int S = (g == 2) ? 0 : (g == 3) ? 3 : 1;
        localparam int W = (g == 1) ? 10 : 8;
        wire [W-1:0] ec_l;
        ic7458_tester #(.SETTLE_CYCLES(S), .ERR_CNT_W(W)) dut (
            .clk(clk), .resetn(rstn[g]), .start(start[g]), .abort(abort[g]),
            .p1a(pv[g][9]), .p1b(pv[g][8]), .p1c(pv[g][7]), .p1d(pv[g][6]),
            .p1e(pv[g][5]), .p1f(pv[g][4]), .p2a(pv[g][3]), .p2b(pv[g][2]),
            .p2c(pv[g][1]), .p2d(pv[g][0]),
            .p1y(y1[g]), .p2y(y2[g]),
            .busy(busy_w[g]), .done(done_w[g]), .pass(pass_w[g]), .err_count(ec_l),
            .first_fail_valid(ffv_w[g]), .first_fail_vec(ffvec[g]), .first_fail_y(ffy[g])
        );
        assign ecw[g] = 10'(ec_l);
    end

    // Reference 7458: gate 1 is high when either 3-input group is all ones, gate 2
    // when either 2-input group is all ones. Returns {y1, y2}.
    function automatic logic [1:0] ref_out(input logic [9:0] v);
        logic [1:0] r;
        r[1] = (v[9:7] == 3'b111) || (v[6:4] == 3'b111);
        r[0] = (v[3:2] == 2'b11) || (v[1:0] == 2'b11);
        return r;
    endfunction

    function automatic logic [1:0] fault_y(input int i, input logic [9:0] v);
        logic [1:0] r;
        r = ref_out(v);
        case (fm[i])
            1:       r[0] = 1'b0;
            2:       r[1] = 1'b1;
            3:       r = r ^ {flip1[v], flip2[v]};
            default: ;
        endcase
        return r;
    endfunction

    // The chip under test settles well within a cycle of a new vector.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            logic [1:0] yy;
            yy = fault_y(i, pv[i]);
            y1[i] = yy[1];
            y2[i] = yy[0];
        end
    end

    task automatic model(input int i, input int upto, output int cnt, output int first,
                         output logic [1:0] fy);
        logic [1:0] got, ex;
        cnt = 0; first = 0; fy = 2'b00;
        for (int v = 0; v < upto; v++) begin
            got = fault_y(i, 10'(v));
            ex  = ref_out(10'(v));
            if (got !== ex) begin
                if (cnt == 0) begin first = v; fy = got ^ ex; end
                cnt++;
            end
        end
    endtask

    task automatic run_full(input int i, input int s, input int w, input string tag,
                            input bit restart_mid);
        int cnt, first, exp_err, exp_edge, n;
        logic [1:0] fy;
        bit seen;
        model(i, 1024, cnt, first, fy);
        exp_err  = (cnt > (1 << w) - 1) ? (1 << w) - 1 : cnt;
        exp_edge = 1024 * (s + 2);
        start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
        checks++; if (busy_w[i] !== 1'b1 || pass_w[i] !== 1'b0) begin failures++;
            $display("FAIL %s run_begin busy=%b pass=%b want busy=1 pass=0", tag, busy_w[i], pass_w[i]); end
        seen = 0; n = 0;
        while (!seen && n < exp_edge + 16) begin
            @(posedge clk); n++; #1;
            if (restart_mid && n == 499) start[i] = 1'b1;
            if (restart_mid && n == 503) start[i] = 1'b0;
            if (done_w[i]) seen = 1;
        end
        checks++; if (!seen || n != exp_edge) begin failures++;
            $display("FAIL %s done_edge got=%0d seen=%0d want=%0d", tag, n, seen, exp_edge); end
        checks++; if (pass_w[i] !== (cnt == 0)) begin failures++;
            $display("FAIL %s pass got=%b want=%b", tag, pass_w[i], cnt == 0); end
        checks++; if (ecw[i] !== 10'(exp_err)) begin failures++;
            $display("FAIL %s err_count got=%0d want=%0d", tag, ecw[i], exp_err); end
        checks++; if (ffv_w[i] !== (cnt != 0) || ffvec[i] !== 10'(first) || ffy[i] !== fy) begin
            failures++;
            $display("FAIL %s first_fail got v=%b vec=%h y=%b want v=%b vec=%h y=%b", tag,
                     ffv_w[i], ffvec[i], ffy[i], cnt != 0, 10'(first), fy); end
        @(posedge clk); #1;
        checks++; if (done_w[i] !== 1'b0 || busy_w[i] !== 1'b0 || pv[i] !== 10'd0
                      || ecw[i] !== 10'(exp_err) || pass_w[i] !== (cnt == 0)) begin failures++;
            $display("FAIL %s after_done done=%b busy=%b pv=%h err=%0d pass=%b", tag,
                     done_w[i], busy_w[i], pv[i], ecw[i], pass_w[i]); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy_w[i], done_w[i], pass_w[i], ffv_w[i], ecw[i], ffvec[i], ffy[i], pv[i]} !== 34'd0) begin
                failures++;
                $display("FAIL reset_state dut%0d busy=%b done=%b pass=%b ffv=%b err=%0d vec=%h y=%b pv=%h want all 0",
                         i, busy_w[i], done_w[i], pass_w[i], ffv_w[i], ecw[i], ffvec[i], ffy[i], pv[i]);
            end
        end
        rstn = 4'b1111;
        @(posedge clk); #1;
    endtask

    task automatic test_loopback();
        fm[0] = 0;
        run_full(0, 1, 8, "loopback", 1'b0);
        run_full(0, 1, 8, "restart_ignored", 1'b1);
    endtask

    task automatic test_stuck();
        fm[0] = 1; fm[1] = 1;
        run_full(0, 1, 8, "p2y_stuck0_w8", 1'b0);
        run_full(1, 1, 10, "p2y_stuck0_w10", 1'b0);
        fm[1] = 2;
        run_full(1, 1, 10, "p1y_stuck1_w10", 1'b0);
        fm[0] = 0; fm[1] = 0;
    endtask

    task automatic test_settle();
        run_full(2, 0, 8, "settle0", 1'b0);
        run_full(3, 3, 8, "settle3", 1'b0);
    endtask

    task automatic test_random_flips();
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 1024; v++) begin
                flip1[v] = ($urandom_range(9) == 0);
                flip2[v] = ($urandom_range(9) == 0);
            end
            fm[r] = 3;
            run_full(r, 1, (r == 1) ? 10 : 8, (r == 1) ? "random_w10" : "random_w8", 1'b0);
            fm[r] = 0;
        end
    endtask

    task automatic test_abort();
        int cnt, first, dones;
        logic [1:0] fy;
        fm[1] = 2;
        model(1, 100 / 3, cnt, first, fy);
        start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        repeat (100) @(posedge clk);
        #1 abort[1] = 1'b1;
        @(posedge clk); #1 abort[1] = 1'b0;
        checks++; if (busy_w[1] !== 1'b0 || pass_w[1] !== 1'b0 || pv[1] !== 10'd0) begin failures++;
            $display("FAIL abort_stop busy=%b pass=%b pv=%h want 0 0 0", busy_w[1], pass_w[1], pv[1]); end
        checks++; if (ecw[1] !== 10'(cnt) || ffv_w[1] !== 1'b1 || ffvec[1] !== 10'(first) || ffy[1] !== fy) begin
            failures++;
            $display("FAIL abort_partial err=%0d ffv=%b vec=%h y=%b want err=%0d ffv=1 vec=%h y=%b",
                     ecw[1], ffv_w[1], ffvec[1], ffy[1], cnt, 10'(first), fy); end
        dones = 0;
        repeat (3200) begin @(posedge clk); #1 if (done_w[1] || busy_w[1]) dones++; end
        checks++; if (dones !== 0) begin failures++;
            $display("FAIL abort_no_done active_cycles got=%0d want=0", dones); end
        run_full(1, 1, 10, "after_abort", 1'b0);
        fm[1] = 0;
    endtask

    task automatic test_start_held();
        int n, k;
        bit seen;
        start[2] = 1'b1;
        @(posedge clk);
        seen = 0; n = 0;
        while (!seen && n < 2100) begin @(posedge clk); n++; #1 if (done_w[2]) seen = 1; end
        checks++; if (!seen || n != 2048) begin failures++;
            $display("FAIL held_done_edge got=%0d want=2048", n); end
        k = 0;
        while (!busy_w[2] && k < 4) begin @(posedge clk); k++; #1; end
        checks++; if (busy_w[2] !== 1'b1 || pass_w[2] !== 1'b0) begin failures++;
            $display("FAIL held_restart busy=%b pass=%b after %0d cycles want busy=1 pass=0", busy_w[2], pass_w[2], k); end
        start[2] = 1'b0; abort[2] = 1'b1;
        @(posedge clk); #1 abort[2] = 1'b0;
        checks++; if (busy_w[2] !== 1'b0 || done_w[2] !== 1'b0) begin failures++;
            $display("FAIL held_abort busy=%b done=%b want 0 0", busy_w[2], done_w[2]); end
    endtask

    task automatic test_reset_midrun();
        int dones;
        fm[0] = 0;
        start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        repeat (1500) @(posedge clk);
        #1;
        checks++; if (pv[0] !== 10'd500 || busy_w[0] !== 1'b1) begin failures++;
            $display("FAIL midrun_vector pv=%0d busy=%b want pv=500 busy=1", pv[0], busy_w[0]); end
        rstn[0] = 1'b0;
        #1;
        checks++;
        if ({busy_w[0], done_w[0], pass_w[0], ffv_w[0], ecw[0], ffvec[0], ffy[0], pv[0]} !== 34'd0) begin
            failures++;
            $display("FAIL midrun_reset busy=%b done=%b pass=%b ffv=%b err=%0d vec=%h y=%b pv=%h want all 0",
                     busy_w[0], done_w[0], pass_w[0], ffv_w[0], ecw[0], ffvec[0], ffy[0], pv[0]);
        end
        repeat (2) @(posedge clk);
        #1 rstn[0] = 1'b1;
        dones = 0;
        repeat (20) begin @(posedge clk); #1 if (done_w[0] || busy_w[0]) dones++; end
        checks++; if (dones !== 0) begin failures++;
            $display("FAIL reset_release_quiet active_cycles got=%0d want=0", dones); end
        run_full(0, 1, 8, "after_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_stuck();
        test_settle();
        test_random_flips();
        test_abort();
        test_start_held();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
